wam_whk: RTL and testbench

//  Responder side of the mole handshake. wam_gen raises holes[i] to show a mole;

---
 rtl/wam_pkg.sv | 16 +
 rtl/wam_deb.sv | 45 ++++
 rtl/wam_whk.sv | 101 ++++++++++
 tb/tb_wam_whk.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// wam_pkg: shared constants and lane state encoding for the whack-a-mole responder.
package wam_pkg;
   localparam int N_HOLES      = 8;
   localparam int DB_LIMIT_DEF = 100000;
   localparam int LOCK_CYC_DEF = 50000000;
   localparam int KILL_TO_DEF  = 1000000;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_KILL = 2'd2,
      ST_LOCK = 2'd3
   } lane_st_e;
   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/wam_deb.sv
// wam_deb: one lane's synchroniser, debouncer, prime bit and whack strobe.
// The first settled level after reset is adopted silently so a switch left up never scores.
module wam_deb #(
   parameter int DB_LIMIT = wam_pkg::DB_LIMIT_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic sw_i,
   output logic whack_o
);
   localparam int CW = $clog2(DB_LIMIT + 1);
   logic          s1_q, s2_q;
   logic          acc_q, acc_d;
   logic          prime_q, prime_d;
   logic          whack_q, whack_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          diff, done;
   assign diff = s2_q != acc_q;
   assign done = cnt_q == CW'(DB_LIMIT - 1);
   // Unprimed: follow the level and count stability; primed: count how long it differs.
   always_comb begin
      acc_d   = (diff && (!prime_q || done)) ? s2_q : acc_q;
      prime_d = prime_q | (!diff & done);
      whack_d = prime_q & diff & done;
      cnt_d   = (done || (diff ^ prime_q)) ? '0 : cnt_q + CW'(1);
   end
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         acc_q   <= 1'b0;
         prime_q <= 1'b0;
         whack_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= sw_i;
         s2_q    <= s1_q;
         acc_q   <= acc_d;
         prime_q <= prime_d;
         whack_q <= whack_d;
         cnt_q   <= cnt_d;
      end
   end
   assign whack_o = whack_q;
endmodule

// File: rtl/wam_whk.sv
// wam_whk: responder side of the mole handshake; classifies each whack as hit or miss
// and holds kill until the generator drops the mole or the kill timeout expires.
module wam_whk #(
   parameter int N_HOLES  = wam_pkg::N_HOLES,
   parameter int DB_LIMIT = wam_pkg::DB_LIMIT_DEF,
   parameter int LOCK_CYC = wam_pkg::LOCK_CYC_DEF,
   parameter int KILL_TO  = wam_pkg::KILL_TO_DEF
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [N_HOLES-1:0] sw,
   input  logic [N_HOLES-1:0] holes,
   output logic [N_HOLES-1:0] kill,
   output logic [N_HOLES-1:0] hit,
   output logic [N_HOLES-1:0] miss,
   output logic [N_HOLES-1:0] busy
);
   import wam_pkg::*;
   localparam int TW = $clog2(max_i(LOCK_CYC, KILL_TO) + 1);
   lane_st_e           st_q  [N_HOLES];
   logic [TW-1:0]      tmr_q [N_HOLES];
   logic [N_HOLES-1:0] whack;
   logic [N_HOLES-1:0] kill_q, hit_q, miss_q, busy_q;
   for (genvar g = 0; g < N_HOLES; g++) begin : g_deb
      wam_deb #(.DB_LIMIT(DB_LIMIT)) u_deb (
         .clk    (clk),
         .clr    (clr),
         .sw_i   (sw[g]),
         .whack_o(whack[g])
      );
   end
   // Timer saturates at all-ones; every state entry reloads it to zero.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         kill_q <= '0;
         hit_q  <= '0;
         miss_q <= '0;
         busy_q <= '0;
         for (int i = 0; i < N_HOLES; i++) begin
            st_q[i]  <= ST_IDLE;
            tmr_q[i] <= '0;
         end
      end else begin
         hit_q  <= '0;
         miss_q <= '0;
         for (int i = 0; i < N_HOLES; i++) begin
            if (tmr_q[i] != '1) tmr_q[i] <= tmr_q[i] + TW'(1);
            case (st_q[i])
               ST_IDLE: begin
                  if (whack[i]) begin
                     tmr_q[i]  <= '0;
                     busy_q[i] <= 1'b1;
                     if (holes[i]) begin
                        hit_q[i]  <= 1'b1;
                        kill_q[i] <= 1'b1;
                        st_q[i]   <= ST_KILL;
                     end else begin
                        miss_q[i] <= 1'b1;
                        st_q[i]   <= ST_LOCK;
                     end
                  end else if (holes[i]) begin
                     tmr_q[i] <= '0;
                     st_q[i]  <= ST_UP;
                  end
               end
               ST_UP: begin
                  if (whack[i]) begin
                     tmr_q[i]  <= '0;
                     busy_q[i] <= 1'b1;
                     hit_q[i]  <= 1'b1;
                     kill_q[i] <= 1'b1;
                     st_q[i]   <= ST_KILL;
                  end else if (!holes[i]) begin
                     tmr_q[i] <= '0;
                     st_q[i]  <= ST_IDLE;
                  end
               end
               ST_KILL: begin
                  if (!holes[i] || tmr_q[i] == TW'(KILL_TO - 1)) begin
                     tmr_q[i]  <= '0;
                     kill_q[i] <= 1'b0;
                     busy_q[i] <= 1'b0;
                     st_q[i]   <= ST_IDLE;
                  end
               end
               ST_LOCK: begin
                  if (tmr_q[i] == TW'(LOCK_CYC - 1)) begin
                     tmr_q[i]  <= '0;
                     busy_q[i] <= 1'b0;
                     st_q[i]   <= holes[i] ? ST_UP : ST_IDLE;
                  end
               end
            endcase
         end
      end
   end
   assign kill = kill_q;
   assign hit  = hit_q;
   assign miss = miss_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_wam_whk.sv
// tb_wam_whk: directed stimulus with a scoreboard of expected hit/miss pulses and their cycle.
module tb_wam_whk;
   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] sw = 8'h01;
   logic [7:0] holes = 8'h00;
   logic [7:0] kill, hit, miss, busy;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   typedef struct {
      logic [7:0] h;
      logic [7:0] m;
      int         c;
   } exp_t;
   exp_t q[$];
   exp_t e;

   wam_whk #(.N_HOLES(8), .DB_LIMIT(4), .LOCK_CYC(8), .KILL_TO(16)) dut (
      .clk  (clk),
      .clr  (clr),
      .sw   (sw),
      .holes(holes),
      .kill (kill),
      .hit  (hit),
      .miss (miss),
      .busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every hit/miss pulse must match the next queued expectation, including its cycle.
   always @(negedge clk) begin
      if (!clr && (hit != 8'h00 || miss != 8'h00)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected hit=%h miss=%h cyc=%0d", hit, miss, cyc);
         end else begin
            e = q.pop_front();
            if (hit !== e.h || miss !== e.m || cyc != e.c) begin
               errors++;
               $display("FAIL pulse got hit=%h miss=%h cyc=%0d want hit=%h miss=%h cyc=%0d",
                        hit, miss, cyc, e.h, e.m, e.c);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_pulse(input logic [7:0] h, input logic [7:0] m, input int c);
      q.push_back('{h: h, m: m, c: c});
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   initial begin
      tick(3);
      clr = 1'b0;
      tick(20);
      chk("t1_kill", kill, 8'h00);
      chk("t1_busy", busy, 8'h00);
      chk("t1_hit", hit, 8'h00);
      chk("t1_miss", miss, 8'h00);

      holes = 8'h04;
      tick(2);
      sw[2] = 1'b1;
      expect_pulse(8'h04, 8'h00, cyc + 7);
      tick(7);
      chk("t2_kill_rise", kill, 8'h04);
      chk("t2_busy", busy, 8'h04);
      tick(3);
      chk("t2_kill_hold", kill, 8'h04);
      holes = 8'h00;
      tick(1);
      chk("t2_kill_drop", kill, 8'h00);
      chk("t2_busy_drop", busy, 8'h00);

      sw[5] = 1'b1;
      expect_pulse(8'h00, 8'h20, cyc + 7);
      tick(7);
      chk("t3_busy_rise", busy, 8'h20);
      sw[5] = 1'b0;
      tick(7);
      chk("t3_busy_last", busy, 8'h20);
      tick(1);
      chk("t3_busy_end", busy, 8'h00);
      sw[5] = 1'b1;
      expect_pulse(8'h00, 8'h20, cyc + 7);
      tick(16);
      chk("t3_busy_idle", busy, 8'h00);

      holes = 8'h02;
      tick(2);
      for (int k = 0; k < 15; k++) begin
         sw[1] = ~sw[1];
         if (k == 14) expect_pulse(8'h02, 8'h00, cyc + 7);
         tick(2);
      end
      tick(10);
      chk("t4_kill", kill, 8'h02);
      holes = 8'h00;
      tick(1);
      chk("t4_kill_drop", kill, 8'h00);

      holes = 8'h08;
      tick(2);
      sw[3] = 1'b1;
      expect_pulse(8'h08, 8'h00, cyc + 7);
      tick(7);
      chk("t5_kill_rise", kill, 8'h08);
      tick(15);
      chk("t5_kill_last", kill, 8'h08);
      tick(1);
      chk("t5_kill_timeout", kill, 8'h00);
      tick(4);
      chk("t5_kill_after", kill, 8'h00);
      chk("t5_busy_after", busy, 8'h00);
      holes = 8'h00;
      tick(2);

      holes = 8'h01;
      tick(2);
      sw[0] = 1'b0;
      sw[7] = 1'b1;
      expect_pulse(8'h01, 8'h80, cyc + 7);
      tick(7);
      chk("t6_kill", kill, 8'h01);
      chk("t6_busy", busy, 8'h81);
      tick(2);
      #2;
      clr = 1'b1;
      #1;
      chk("t6_clr_kill", kill, 8'h00);
      chk("t6_clr_busy", busy, 8'h00);
      tick(2);
      clr = 1'b0;
      tick(20);
      chk("t6_post_busy", busy, 8'h00);
      sw[0] = 1'b1;
      expect_pulse(8'h01, 8'h00, cyc + 7);
      tick(7);
      chk("t6_rehit_kill", kill, 8'h01);
      holes = 8'h00;
      tick(1);
      chk("t6_rehit_drop", kill, 8'h00);
      tick(10);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pulses_missing got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
